// File: rtl/pc_sequencer.sv
// pc_sequencer: program-flow controller for the 5-bit PC / 6-bit program
// memory / instruction-decoder core. Owns the PC, executes control opcodes
// (JMP, JZ, CALL, RET, HALT) itself and hands ordinary instructions to the
// decoder through IR.
//
// Build option: define CALL_STACK_EN to enable CALL/RET and the return
// stack. Without it, CALL/RET codes are ordinary instructions and StackErr
// is tied low.
//
// Ports:
//   clk       rising-edge clock
//   Reset     synchronous, active-high reset
//   Ins       instruction word at Addr (combinational program memory)
//   Flag_Z    ALU zero flag, used only by JZ in the operand cycle
//   Stall     freeze all state for one cycle
//   Addr      program counter / program memory address
//   IR        last ordinary instruction for the decoder
//   IR_Valid  one-cycle pulse when IR was loaded
//   Halted    sequencer is in HALT
//   StackErr  sticky return-stack overflow/underflow flag
module pc_sequencer #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned INS_W       = 6,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [INS_W-1:0]  Ins,
  input  logic              Flag_Z,
  input  logic              Stall,
  output logic [ADDR_W-1:0] Addr,
  output logic [INS_W-1:0]  IR,
  output logic              IR_Valid,
  output logic              Halted,
  output logic              StackErr
);

  // Elaboration-time guard on the stack depth range.
  if (STACK_DEPTH < 1 || STACK_DEPTH > 8) begin : g_depth_check
    $error("pc_sequencer: STACK_DEPTH must be 1..8");
  end

  localparam logic [INS_W-1:0] OPC_JMP  = INS_W'(6'b111000);
  localparam logic [INS_W-1:0] OPC_JZ   = INS_W'(6'b111001);
  localparam logic [INS_W-1:0] OPC_HALT = INS_W'(6'b111111);

  typedef enum logic [1:0] {ST_RUN, ST_OPER, ST_HALT} state_t;
  typedef enum logic [1:0] {OP_JMP, OP_JZ, OP_CALL} op_t;

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INS_W-1:0]  ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              halted_q;

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;
  logic              is_jmp, is_jz, is_halt, is_two_word;

  // Target word of a two-word instruction: low ADDR_W bits, upper bits ignored.
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign target  = Ins[ADDR_W-1:0];
  assign is_jmp  = (Ins == OPC_JMP);
  assign is_jz   = (Ins == OPC_JZ);
  assign is_halt = (Ins == OPC_HALT);

`ifdef CALL_STACK_EN
  localparam logic [INS_W-1:0] OPC_CALL = INS_W'(6'b111010);
  localparam logic [INS_W-1:0] OPC_RET  = INS_W'(6'b111011);
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              err_q, err_d;
  logic              push_c;
  logic              is_call, is_ret;
  logic [ADDR_W-1:0] top_c;

  assign is_call     = (Ins == OPC_CALL);
  assign is_ret      = (Ins == OPC_RET);
  assign is_two_word = is_jmp | is_jz | is_call;
  // Top-of-stack entry; only consumed when the stack is non-empty.
  assign top_c       = stack_q[IDX_W'(sp_q - SP_W'(1))];
`else
  assign is_two_word = is_jmp | is_jz;
`endif

  // Next-state, PC, IR and stack control.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
`ifdef CALL_STACK_EN
    sp_d       = sp_q;
    err_d      = err_q;
    push_c     = 1'b0;
`endif
    if (!Stall) begin
      case (state_q)
        ST_RUN: begin
          if (is_halt) begin
            state_d = ST_HALT;
          end else if (is_two_word) begin
            if (is_jmp)     op_d = OP_JMP;
            else if (is_jz) op_d = OP_JZ;
            else            op_d = OP_CALL;
            pc_d    = pc_inc;
            state_d = ST_OPER;
          end
`ifdef CALL_STACK_EN
          else if (is_ret) begin
            if (sp_q != SP_W'(0)) begin
              pc_d = top_c;
              sp_d = sp_q - SP_W'(1);
            end else begin
              err_d = 1'b1;
              pc_d  = pc_inc;
            end
          end
`endif
          else begin
            ir_d       = Ins;
            ir_valid_d = 1'b1;
            pc_d       = pc_inc;
          end
        end
        ST_OPER: begin
          state_d = ST_RUN;
          case (op_q)
            OP_JMP:  pc_d = target;
            OP_JZ:   pc_d = Flag_Z ? target : pc_inc;
            OP_CALL: begin
`ifdef CALL_STACK_EN
              // A full stack drops the return address but still jumps.
              if (sp_q == SP_W'(STACK_DEPTH)) begin
                err_d = 1'b1;
              end else begin
                push_c = 1'b1;
                sp_d   = sp_q + SP_W'(1);
              end
`endif
              pc_d = target;
            end
            default: pc_d = target;
          endcase
        end
        ST_HALT: ;
        default: state_d = ST_RUN;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= ST_RUN;
      op_q       <= OP_JMP;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
`ifdef CALL_STACK_EN
      sp_q       <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= (state_d == ST_HALT);
`ifdef CALL_STACK_EN
      sp_q       <= sp_d;
      err_q      <= err_d;
`endif
    end
  end

`ifdef CALL_STACK_EN
  // Return-stack storage; pushes the address after the CALL operand.
  always_ff @(posedge clk) begin
    if (!Reset && push_c) begin
      stack_q[IDX_W'(sp_q)] <= pc_inc;
    end
  end

  assign StackErr = err_q;
`else
  assign StackErr = 1'b0;
`endif

  assign Addr     = pc_q;
  assign IR       = ir_q;
  assign IR_Valid = ir_valid_q;
  assign Halted   = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed programs in a bench-owned program
// memory, per-cycle expectations queued by the stimulus and checked by an
// independent monitor. Stack scenarios run when CALL_STACK_EN is defined.
module tb_pc_sequencer;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned INS_W  = 6;

  localparam logic [5:0] JMP  = 6'b111000;
  localparam logic [5:0] JZ   = 6'b111001;
  localparam logic [5:0] CALL = 6'b111010;
  localparam logic [5:0] RET  = 6'b111011;
  localparam logic [5:0] HLT  = 6'b111111;

  logic              clk = 1'b0;
  logic              Reset = 1'b1;
  logic              Stall = 1'b0;
  logic              Flag_Z = 1'b0;
  logic [INS_W-1:0]  Ins;
  logic [ADDR_W-1:0] Addr;
  logic [INS_W-1:0]  IR;
  logic              IR_Valid;
  logic              Halted;
  logic              StackErr;

  logic [INS_W-1:0] mem [32];

  assign Ins = mem[Addr];

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(ADDR_W), .INS_W(INS_W), .STACK_DEPTH(4)) dut (
    .clk(clk), .Reset(Reset), .Ins(Ins), .Flag_Z(Flag_Z), .Stall(Stall),
    .Addr(Addr), .IR(IR), .IR_Valid(IR_Valid), .Halted(Halted),
    .StackErr(StackErr)
  );

  typedef struct {
    int         tag;
    logic [4:0] addr;
    logic       v;
    logic [5:0] ir;
    logic       h;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   tag      = 0;
  logic exp_err  = 1'b0;

  task automatic chk(input string name, input int t, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, t, act, req);
    end
  endtask

  // Monitor: after every edge, compare outputs with the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("addr",      e.tag, 8'(Addr),     8'(e.addr));
        chk("ir_valid",  e.tag, 8'(IR_Valid), 8'(e.v));
        if (e.v) chk("ir", e.tag, 8'(IR), 8'(e.ir));
        chk("halted",    e.tag, 8'(Halted),   8'(e.h));
        chk("stack_err", e.tag, 8'(StackErr), 8'(e.e));
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic rst, input logic stl, input logic fz,
                      input int ea, input logic ev, input int eir, input logic eh);
    exp_t e;
    @(negedge clk);
    Reset  = rst;
    Stall  = stl;
    Flag_Z = fz;
    tag++;
    e.tag  = tag;
    e.addr = 5'(ea);
    e.v    = ev;
    e.ir   = 6'(eir);
    e.h    = eh;
    e.e    = exp_err;
    sb.push_back(e);
  endtask

  task automatic load_default();
    for (int i = 0; i < 32; i++) mem[i] = 6'(i);
  endtask

  // Reset cycle; the memory is reloaded while Reset is asserted.
  task automatic do_reset();
    exp_err = 1'b0;
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    load_default();
  endtask

  // n ordinary instructions starting at 'start' (default memory: word = address).
  task automatic run(input int n, input int start);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'b0, (start + i + 1) % 32, 1'b1, start + i, 1'b0);
  endtask

  task automatic ctl(input int ea);
    step(1'b0, 1'b0, 1'b0, ea, 1'b0, 0, 1'b0);
  endtask

  initial begin : stimulus
    load_default();

    // Linear code.
    do_reset();
    run(4, 0);

    // JMP 5 -> 20, JMP 22 -> 30 (operand bit 5 set), wrap 31 -> 0.
    do_reset();
    mem[5]  = JMP;  mem[6]  = 6'h14;
    mem[22] = JMP;  mem[23] = 6'h3E;
    run(5, 0);
    ctl(6);
    ctl(20);
    run(2, 20);
    ctl(23);
    ctl(30);
    run(2, 30);
    run(1, 0);

    // JZ not taken; Flag_Z high in the opcode cycle must be ignored.
    do_reset();
    mem[3] = JZ; mem[4] = 6'h0A;
    run(3, 0);
    step(1'b0, 1'b0, 1'b1, 4, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 5, 1'b0, 0, 1'b0);
    run(1, 5);

    // JZ taken.
    do_reset();
    mem[3] = JZ; mem[4] = 6'h0A;
    run(3, 0);
    ctl(4);
    step(1'b0, 1'b0, 1'b1, 10, 1'b0, 0, 1'b0);
    run(1, 10);

    // Stall in RUN, then three stall cycles in OPER.
    do_reset();
    mem[5] = JMP; mem[6] = 6'h14;
    run(2, 0);
    step(1'b0, 1'b1, 1'b0, 2, 1'b0, 0, 1'b0);
    run(3, 2);
    ctl(6);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 6, 1'b0, 0, 1'b0);
    ctl(20);
    run(1, 20);

    // Reset in the middle of a JMP discards it.
    do_reset();
    mem[5] = JMP; mem[6] = 6'h14;
    run(5, 0);
    ctl(6);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    run(1, 0);

    // HALT at 8, stall ignored, reset leaves HALT.
    do_reset();
    mem[8] = HLT;
    run(8, 0);
    step(1'b0, 1'b0, 1'b0, 8, 1'b0, 0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8, 1'b0, 0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8, 1'b0, 0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    run(1, 0);

`ifdef CALL_STACK_EN
    // CALL 2 -> 10, RET at 10 returns to 4.
    do_reset();
    mem[2] = CALL; mem[3] = 6'h0A; mem[10] = RET;
    run(2, 0);
    ctl(3);
    ctl(10);
    ctl(4);
    run(1, 4);

    // Five nested CALLs on a 4-deep stack; fifth push dropped, jump taken.
    do_reset();
    mem[0]  = CALL; mem[1]  = 6'd4;
    mem[4]  = CALL; mem[5]  = 6'd8;
    mem[8]  = CALL; mem[9]  = 6'd12;
    mem[12] = CALL; mem[13] = 6'd16;
    mem[16] = CALL; mem[17] = 6'd20;
    mem[20] = RET;
    ctl(1);  ctl(4);
    ctl(5);  ctl(8);
    ctl(9);  ctl(12);
    ctl(13); ctl(16);
    ctl(17);
    exp_err = 1'b1;
    ctl(20);
    ctl(14);
    run(1, 14);

    // RET on an empty stack.
    do_reset();
    mem[0] = RET;
    exp_err = 1'b1;
    ctl(1);
    run(1, 1);
`else
    // CALL/RET codes are ordinary instructions in this build.
    do_reset();
    mem[0] = CALL; mem[1] = RET;
    step(1'b0, 1'b0, 1'b0, 1, 1'b1, 6'h3A, 1'b0);
    step(1'b0, 1'b0, 1'b0, 2, 1'b1, 6'h3B, 1'b0);
`endif

    repeat (2) @(posedge clk);
    #5;
    if (sb.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
